// File: rtl/arbitro_fifos_if.sv
// Bus between the source FIFO bank, the arbiter and the destination FIFO bank.
// The arbiter side is the master: it owns every pop and every push.
interface arbitro_fifos_if #(
    parameter int DATA_W = 6
);
    logic                active_in;
    logic [3:0]          fifo_empty;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          dest_almost_full;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    logic [1:0]          grant;
    logic                busy;

    modport master (
        input  active_in, fifo_empty, data_in, dest_almost_full,
        output pop, push, data_out, grant, busy
    );

    modport slave (
        output active_in, fifo_empty, data_in, dest_almost_full,
        input  pop, push, data_out, grant, busy
    );
endinterface

// File: rtl/arbitro_fifos.sv
// Round-robin burst arbiter draining four source FIFOs into four destination FIFOs.
// Define ARB_FIXED_PRIO_EN for lowest-index-first priority with a combinational grant.
module arbitro_fifos #(
    parameter int DATA_W = 6,
    parameter int BURST  = 4
) (
    input logic             clk,
    input logic             reset,
    arbitro_fifos_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                any_af_s;
    logic [3:0]          pop_s;
    logic [1:0]          grant_s;
    logic                v1_r;
    logic [1:0]          src1_r;
    logic [DATA_W-1:0]   word_s;
    logic [3:0]          push_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                busy_r;

    function automatic logic [3:0] dest_onehot(input logic [1:0] dest);
        logic [3:0] res;
        case (dest)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    assign any_af_s = |bus.dest_almost_full;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; losing active_in overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.active_in) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = RUN;
                RUN:     state_nxt_s = any_af_s ? PAUSE : RUN;
                PAUSE:   state_nxt_s = any_af_s ? PAUSE : RUN;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Pop uses the live almost-full flags so a pause bites in the same cycle
    always_comb begin
        pop_s = 4'b0000;
        if ((state_r == RUN) && bus.active_in && !any_af_s && !bus.fifo_empty[grant_s]) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = 4'b0000;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Lowest-index non-empty source wins, re-evaluated every cycle
    always_comb begin
        grant_s = 2'd0;
        if (!bus.fifo_empty[0]) begin
            grant_s = 2'd0;
        end else if (!bus.fifo_empty[1]) begin
            grant_s = 2'd1;
        end else if (!bus.fifo_empty[2]) begin
            grant_s = 2'd2;
        end else if (!bus.fifo_empty[3]) begin
            grant_s = 2'd3;
        end else begin
            grant_s = 2'd0;
        end
    end
`else
    localparam int               CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       grant_r;
    logic [2:0]       next_s;

    // Returns {found, index} of the first non-empty source after cur, in circular order
    function automatic logic [2:0] next_src(input logic [1:0] cur, input logic [3:0] empty);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, cur};
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (!empty[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign next_s  = next_src(grant_r, bus.fifo_empty);
    assign grant_s = grant_r;

    // Grant and burst counter; an empty grant costs one bubble cycle to move on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r <= 2'd0;
            cnt_r   <= '0;
        end else if ((state_r == RUN) && bus.fifo_empty[grant_r]) begin
            cnt_r   <= '0;
            grant_r <= next_s[2] ? next_s[1:0] : grant_r;
        end else if (|pop_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                grant_r <= next_s[2] ? next_s[1:0] : grant_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                grant_r <= grant_r;
            end
        end else begin
            cnt_r   <= cnt_r;
            grant_r <= grant_r;
        end
    end
`endif

    assign word_s = bus.data_in[src1_r*DATA_W +: DATA_W];

    // Two-stage in-flight pipeline: pop -> source capture -> push of the read word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_r       <= 1'b0;
            src1_r     <= 2'd0;
            push_r     <= 4'b0000;
            data_out_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            v1_r   <= |pop_s;
            src1_r <= (|pop_s) ? grant_s : src1_r;
            if (v1_r) begin
                data_out_r <= word_s;
                push_r     <= dest_onehot(word_s[DATA_W-1:DATA_W-2]);
            end else begin
                data_out_r <= data_out_r;
                push_r     <= 4'b0000;
            end
            // Registered image of: state != IDLE or a word still in the pipeline
            busy_r <= (state_nxt_s != IDLE) | (|pop_s) | v1_r;
        end
    end

    assign bus.pop      = pop_s;
    assign bus.push     = push_r;
    assign bus.data_out = data_out_r;
    assign bus.grant    = grant_s;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_arbitro_fifos.sv
// Directed bench for arbitro_fifos: bench-side source FIFO model and a two-cycle push scoreboard.
// Define ARB_FIXED_PRIO_EN to run the fixed-priority scenario instead of the round-robin ones.
module tb_arbitro_fifos;
    localparam int DATA_W = 6;
    localparam int BURST  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   push_cnt = 0;
    int   pc0;

    logic [DATA_W-1:0] mem [4][16];
    int                rd_ptr [4];
    int                wr_ptr [4];
    logic              pw1_v, pw2_v;
    logic [DATA_W-1:0] pw1, pw2;

    arbitro_fifos_if #(.DATA_W(DATA_W)) bus ();

    arbitro_fifos #(.DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] push_for(input logic [DATA_W-1:0] w);
        logic [1:0] d;
        d = w[DATA_W-1:DATA_W-2];
        return 4'b0001 << d;
    endfunction

    task automatic update_empty();
        for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    endtask

    task automatic load(input int src, input int n, input logic [1:0] dest);
        for (int k = 0; k < n; k++) begin
            mem[src][wr_ptr[src]] = {dest, 4'(k + 1)};
            wr_ptr[src]++;
        end
        update_empty();
    endtask

    // One clock: scoreboard check, source FIFO read on pop, return at next falling edge
    task automatic tick();
        logic [3:0]        p;
        logic [DATA_W-1:0] w;
        int                g;
        #1;
        p = bus.pop;
        check_eq("pop_onehot0", 32'($onehot0(p)), 32'd1);
        check_eq("push", 32'(bus.push), pw2_v ? 32'(push_for(pw2)) : 32'd0);
        if (pw2_v) check_eq("data_out", 32'(bus.data_out), 32'(pw2));
        if (bus.push != 4'b0000) push_cnt++;
        g = 0;
        for (int i = 0; i < 4; i++) if (p[i]) g = i;
        w = mem[g][rd_ptr[g]];
        pw2_v = pw1_v;
        pw2   = pw1;
        pw1_v = |p;
        pw1   = w;
        @(posedge clk);
        #1;
        if (|p && (rd_ptr[g] < wr_ptr[g])) begin
            bus.data_in[g*DATA_W +: DATA_W] = w;
            rd_ptr[g]++;
        end
        update_empty();
        @(negedge clk);
    endtask

    task automatic clear_sb();
        pw1_v = 1'b0;
        pw2_v = 1'b0;
        pw1   = '0;
        pw2   = '0;
    endtask

    task automatic do_reset();
        reset                = 1'b0;
        bus.active_in        = 1'b0;
        bus.dest_almost_full = 4'b0000;
        bus.data_in          = '0;
        for (int i = 0; i < 4; i++) begin
            rd_ptr[i] = 0;
            wr_ptr[i] = 0;
        end
        update_empty();
        clear_sb();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.active_in = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset                = 1'b1;
        bus.active_in        = 1'b0;
        bus.dest_almost_full = 4'b0000;
        bus.fifo_empty       = 4'b1111;
        bus.data_in          = '0;
        clear_sb();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_pop",      32'(bus.pop),      32'd0);
        check_eq("rst_push",     32'(bus.push),     32'd0);
        check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
        check_eq("rst_grant",    32'(bus.grant),    32'd0);
        check_eq("rst_busy",     32'(bus.busy),     32'd0);

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: source 0 drains completely before source 3
        do_reset();
        bus.active_in = 1'b1;
        load(0, 3, 2'd0);
        load(3, 2, 2'd3);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("fp_pop_src0", 32'(bus.pop),   32'h1);
            check_eq("fp_grant0",   32'(bus.grant), 32'd0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("fp_pop_src3", 32'(bus.pop),   32'h8);
            check_eq("fp_grant3",   32'(bus.grant), 32'd3);
            tick();
        end
        #1 check_eq("fp_all_empty_pop", 32'(bus.pop), 32'h0);
        drain();
`else
        // Single source: source 2, three words to destination 1
        do_reset();
        bus.active_in = 1'b1;
        load(2, 3, 2'b01);
        #1 check_eq("t1_idle_pop", 32'(bus.pop), 32'h0);
        tick();
        #1;
        check_eq("t1_bubble_pop",   32'(bus.pop),   32'h0);
        check_eq("t1_bubble_grant", 32'(bus.grant), 32'd0);
        tick();
        #1;
        check_eq("t1_grant", 32'(bus.grant), 32'd2);
        check_eq("t1_pop_t", 32'(bus.pop),   32'h4);
        tick();
        #1 check_eq("t1_pop_t1", 32'(bus.pop), 32'h4);
        tick();
        #1;
        check_eq("t1_pop_t2",  32'(bus.pop),      32'h4);
        check_eq("t1_push_t2", 32'(bus.push),     32'h2);
        check_eq("t1_data_t2", 32'(bus.data_out), 32'h11);
        tick();
        #1 check_eq("t1_pop_t3", 32'(bus.pop), 32'h0);
        tick();
        #1;
        check_eq("t1_push_t4", 32'(bus.push),     32'h2);
        check_eq("t1_data_t4", 32'(bus.data_out), 32'h13);
        tick();
        #1;
        check_eq("t1_push_t5", 32'(bus.push), 32'h0);
        check_eq("t1_busy_t5", 32'(bus.busy), 32'd1);
        drain();

        // Round-robin burst: four pops per source, no bubble at rotation
        do_reset();
        bus.active_in = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 10, 2'(i));
        tick();
        for (int k = 0; k < 17; k++) begin
            #1;
            check_eq("t2_grant", 32'(bus.grant), 32'((k / 4) % 4));
            check_eq("t2_pop",   32'(bus.pop),   32'(4'b0001 << ((k / 4) % 4)));
            tick();
        end
        drain();

        // Pause after two pops from source 1
        do_reset();
        bus.active_in = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 10, 2'(i));
        tick();
        for (int k = 0; k < 6; k++) tick();
        bus.dest_almost_full = 4'b1000;
        #1 check_eq("t3_pop_same_cycle", 32'(bus.pop), 32'h0);
        pc0 = push_cnt;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t3_pause_pop",   32'(bus.pop),   32'h0);
            check_eq("t3_pause_grant", 32'(bus.grant), 32'd1);
            tick();
        end
        check_eq("t3_drain_pushes", 32'(push_cnt - pc0), 32'd2);
        bus.dest_almost_full = 4'b0000;
        #1 check_eq("t3_resume_delay", 32'(bus.pop), 32'h0);
        tick();
        #1 check_eq("t3_resume_pop1", 32'(bus.pop), 32'h2);
        tick();
        #1 check_eq("t3_resume_pop2", 32'(bus.pop), 32'h2);
        tick();
        #1;
        check_eq("t3_rotate_grant", 32'(bus.grant), 32'd2);
        check_eq("t3_rotate_pop",   32'(bus.pop),   32'h4);
        tick();
        drain();

        // Deactivate mid-stream, then reset with a word in flight
        do_reset();
        bus.active_in = 1'b1;
        load(0, 10, 2'b10);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1 check_eq("t4_pop", 32'(bus.pop), 32'h1);
            tick();
        end
        bus.active_in = 1'b0;
        #1;
        check_eq("t4_stop_pop", 32'(bus.pop),  32'h0);
        check_eq("t4_busy_a",   32'(bus.busy), 32'd1);
        tick();
        #1;
        check_eq("t4_last_push", 32'(bus.push), 32'h4);
        check_eq("t4_busy_b",    32'(bus.busy), 32'd1);
        tick();
        #1;
        check_eq("t4_push_done", 32'(bus.push), 32'h0);
        check_eq("t4_busy_fall", 32'(bus.busy), 32'd0);
        tick();
        bus.active_in = 1'b1;
        tick();
        tick();
        tick();
        #1 check_eq("t4_push_inflight", 32'(bus.push), 32'h4);
        reset = 1'b0;
        #1;
        check_eq("t4_rst_push",     32'(bus.push),     32'h0);
        check_eq("t4_rst_pop",      32'(bus.pop),      32'h0);
        check_eq("t4_rst_data_out", 32'(bus.data_out), 32'h0);
        check_eq("t4_rst_busy",     32'(bus.busy),     32'd0);
        clear_sb();
        pc0 = push_cnt;
        tick();
        tick();
        reset         = 1'b1;
        bus.active_in = 1'b0;
        repeat (4) tick();
        check_eq("t4_no_late_push", 32'(push_cnt - pc0), 32'd0);

        // Empty grant: source 0 runs dry while holding the grant
        do_reset();
        bus.active_in = 1'b1;
        load(0, 2, 2'b00);
        load(1, 5, 2'b01);
        tick();
        for (int k = 0; k < 2; k++) begin
            #1 check_eq("t5_pop_src0", 32'(bus.pop), 32'h1);
            tick();
        end
        #1;
        check_eq("t5_bubble_pop",   32'(bus.pop),   32'h0);
        check_eq("t5_bubble_grant", 32'(bus.grant), 32'd0);
        tick();
        #1;
        check_eq("t5_new_grant", 32'(bus.grant), 32'd1);
        check_eq("t5_new_pop",   32'(bus.pop),   32'h2);
        tick();
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
